// File: rtl/key_debouncer.sv
// Push-button debouncer: two-flop synchroniser, per-edge stability filter FSM,
// and registered level / press / release outputs for a downstream counter stage.
module key_debouncer #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic             s1_q;
  logic             s2_q;
  logic             k;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser idles at the inactive pad level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  assign k = s2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= CNT_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any sample opposite to the candidate level drops back and restarts the filter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (k) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_PRESS: begin
        if (!k) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!k) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      WAIT_RELEASE: begin
        if (k) begin
          state_d   = PRESSED;
          cnt_d     = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = CNT_ZERO;
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = CNT_ZERO;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4, ACTIVE_LOW=1.
module tb_key_debouncer;

  logic clk;
  logic rst;
  logic key_raw;
  logic key_level;
  logic key_press;
  logic key_release;

  int n_vec;
  int n_err;
  logic bounce_seq [0:4];

  key_debouncer #(
    .STABLE_CYCLES(4),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic lv, input logic pr, input logic rl);
    chk({tag, ".level"}, {31'd0, key_level}, {31'd0, lv});
    chk({tag, ".press"}, {31'd0, key_press}, {31'd0, pr});
    chk({tag, ".release"}, {31'd0, key_release}, {31'd0, rl});
  endtask

  // Advance one clock edge, then sample away from the edge.
  task automatic step(input string tag, input logic lv, input logic pr, input logic rl);
    @(posedge clk);
    #1;
    chk_outs(tag, lv, pr, rl);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clk     = 1'b0;
    rst     = 1'b0;
    key_raw = 1'b1;
    bounce_seq[0] = 1'b0;
    bounce_seq[1] = 1'b1;
    bounce_seq[2] = 1'b0;
    bounce_seq[3] = 1'b0;
    bounce_seq[4] = 1'b1;

    // Reset with key held pressed
    #2;
    key_raw = 1'b0;
    rst     = 1'b1;
    #1;
    chk_outs("rst_async", 1'b0, 1'b0, 1'b0);
    chk("rst_s2", {31'd0, dut.s2_q}, 32'd1);
    for (int i = 1; i <= 3; i++) step("rst_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) step("rst_release", (i >= 6), (i == 6), 1'b0);

    // Holding the key: no auto-repeat
    for (int i = 1; i <= 12; i++) step("hold", 1'b1, 1'b0, 1'b0);

    // Release path
    key_raw = 1'b1;
    for (int i = 1; i <= 7; i++) step("release", (i < 6), 1'b0, (i == 6));

    // Clean press and hold
    key_raw = 1'b0;
    for (int i = 1; i <= 20; i++) step("clean_press", (i >= 6), (i == 6), 1'b0);
    key_raw = 1'b1;
    for (int i = 1; i <= 7; i++) step("clean_release", (i < 6), 1'b0, (i == 6));

    // Bounce then steady press
    for (int i = 1; i <= 12; i++) begin
      key_raw = (i <= 5) ? bounce_seq[i-1] : 1'b0;
      step("bounce", (i >= 11), (i == 11), 1'b0);
    end
    key_raw = 1'b1;
    for (int i = 1; i <= 7; i++) step("bounce_release", (i < 6), 1'b0, (i == 6));

    // Glitch of three samples
    for (int i = 1; i <= 10; i++) begin
      key_raw = (i <= 3) ? 1'b0 : 1'b1;
      step("glitch", 1'b0, 1'b0, 1'b0);
    end

    // Async reset in WAIT_PRESS with cnt=2
    key_raw = 1'b0;
    for (int i = 1; i <= 4; i++) step("mid_filter", 1'b0, 1'b0, 1'b0);
    chk("mid_filter_cnt", {30'd0, dut.cnt_q}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk_outs("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_cnt", {30'd0, dut.cnt_q}, 32'd0);
    chk("mid_rst_s1", {31'd0, dut.s1_q}, 32'd1);
    key_raw = 1'b1;
    for (int i = 1; i <= 2; i++) step("mid_rst_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) step("mid_rst_after", 1'b0, 1'b0, 1'b0);

    // Reset clears a press pulse in flight
    key_raw = 1'b0;
    for (int i = 1; i <= 6; i++) step("flight_press", (i >= 6), (i == 6), 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_outs("flight_rst", 1'b0, 1'b0, 1'b0);
    key_raw = 1'b1;
    for (int i = 1; i <= 2; i++) step("flight_rst_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) step("flight_after", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
